// File: rtl/led_arb_pkg.sv
// Shared types and helpers for the LED burst arbiter: FSM state encoding and
// the blink half-period calculation.
package led_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      OFF  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Clamped to 1 so a too-fast blink rate still yields a legal prescaler.
   function automatic int half_period(input int clk_hz, input int blink_hz);
      int h;
      h = clk_hz / (2 * blink_hz);
      return (h < 1) ? 1 : h;
   endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Half-period prescaler: counts 0..HALF-1 and pulses tick for one cycle at
// HALF-1; clr restarts the count at the next edge.
module led_tick_gen #(
   parameter int HALF = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);

   localparam int            CW   = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [CW-1:0] LAST = CW'(HALF - 1);

   logic [CW-1:0] cnt;

   assign tick = (cnt == LAST);

   // NOTE: sequential state is always assigned with <= so every flop samples
   // the pre-edge value of its inputs regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (clr || tick)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/led_burst_arbiter.sv
// Grants the status LED to one requester at a time and blinks it burst_len
// times. Define LED_ARB_ROUND_ROBIN_EN for round-robin, else fixed priority.
module led_burst_arbiter
   import led_arb_pkg::*;
#(
   parameter int CLK_HZ   = 100_000_000,
   parameter int BLINK_HZ = 2,
   parameter int NREQ     = 2,
   parameter int CNT_W    = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*CNT_W-1:0] burst_len,
   output logic [NREQ-1:0]       gnt,
   output logic [NREQ-1:0]       done,
   output logic                  busy,
   output logic [1:0]            led
);

   localparam int HALF  = half_period(CLK_HZ, BLINK_HZ);
   localparam int IDX_W = $clog2(NREQ);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, win_len;
   logic [IDX_W-1:0]   owner_q, owner_d, win_idx;
   logic               win_valid, tick, clr;
   logic [NREQ-1:0]    owner_oh, win_oh, zl_gnt;
   logic [NREQ-1:0]    gnt_q, gnt_d, done_q, done_d;
   logic               busy_q, busy_d, led0_q, led0_d;

`ifdef LED_ARB_ROUND_ROBIN_EN
   logic [IDX_W-1:0] ptr_q, rr_idx;

   // Scan downward from pointer+NREQ-1 so the lowest index at/after ptr wins.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned and infers a latch.
      win_valid = 1'b0;
      win_idx   = '0;
      rr_idx    = '0;
      for (int off = NREQ - 1; off >= 0; off--) begin
         rr_idx = IDX_W'((int'(ptr_q) + off) % NREQ);
         if (req[rr_idx]) begin
            win_valid = 1'b1;
            win_idx   = rr_idx;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ptr_q <= '0;
      else if (state_q == DONE)
         ptr_q <= (int'(owner_q) == NREQ - 1) ? '0 : owner_q + 1'b1;
   end
`else
   always_comb begin
      win_valid = 1'b0;
      win_idx   = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req[k]) begin
            win_valid = 1'b1;
            win_idx   = IDX_W'(k);
         end
      end
   end
`endif

   always_comb begin
      win_len = '0;
      win_oh  = '0;
      for (int k = 0; k < NREQ; k++) begin
         win_oh[k] = (win_idx == IDX_W'(k));
         if (win_idx == IDX_W'(k))
            win_len = burst_len[k*CNT_W +: CNT_W];
      end
   end

   assign clr = (state_q == IDLE) || (state_q == DONE);

   led_tick_gen #(.HALF(HALF)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .tick  (tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (win_valid) state_d = (win_len != '0) ? ON : DONE;
         ON:      if (tick) state_d = OFF;
         OFF:     if (tick) state_d = (cnt_q < CNT_W'(2)) ? DONE : ON;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign owner_d = (state_q == IDLE && win_valid) ? win_idx : owner_q;

   // Outputs are registered from the next state so they line up with it.
   always_comb begin
      for (int k = 0; k < NREQ; k++)
         owner_oh[k] = (owner_d == IDX_W'(k));
      gnt_d  = (state_d == ON || state_d == OFF) ? owner_oh : '0;
      done_d = (state_d == DONE) ? owner_oh : '0;
      busy_d = (state_d != IDLE);
      led0_d = (state_d == ON);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         owner_q <= '0;
         gnt_q   <= '0;
         done_q  <= '0;
         busy_q  <= 1'b0;
         led0_q  <= 1'b0;
      end else begin
         owner_q <= owner_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         led0_q  <= led0_d;
         if (state_q == IDLE && win_valid)
            cnt_q <= win_len;
         else if (state_q == OFF && tick && cnt_q != '0)
            cnt_q <= cnt_q - 1'b1;
      end
   end

   // A zero-length burst shows its grant during the decision cycle itself.
   assign zl_gnt = (rst_n && state_q == IDLE && win_valid && win_len == '0) ? win_oh : '0;

   assign gnt  = gnt_q | zl_gnt;
   assign done = done_q;
   assign busy = busy_q;
   assign led  = {busy_q, led0_q};

endmodule

// File: tb/tb_led_burst_arbiter.sv
// Scoreboard bench for led_burst_arbiter at HALF=4: stimulus queues expected
// bursts, a negedge monitor checks each one when its done pulse appears.
module tb_led_burst_arbiter;

   localparam int NREQ  = 2;
   localparam int CNT_W = 4;

   typedef struct {
      logic [NREQ-1:0] gnt;
      int              pulses;
      int              cycles;
   } exp_t;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [NREQ-1:0]    req;
   logic [NREQ*CNT_W-1:0] burst_len;
   logic [NREQ-1:0]    gnt, done;
   logic               busy;
   logic [1:0]         led;

   int   vectors     = 0;
   int   miscompares = 0;
   exp_t sb[$];

   led_burst_arbiter #(
      .CLK_HZ   (8),
      .BLINK_HZ (1),
      .NREQ     (NREQ),
      .CNT_W    (CNT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .burst_len (burst_len),
      .gnt       (gnt),
      .done      (done),
      .busy      (busy),
      .led       (led)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_exp(input logic [NREQ-1:0] g, input int p, input int c);
      exp_t e;
      e.gnt    = g;
      e.pulses = p;
      e.cycles = c;
      sb.push_back(e);
   endtask

   task automatic wait_dones(input int n, input int max_cycles);
      int seen;
      seen = 0;
      for (int c = 0; c < max_cycles && seen < n; c++) begin
         @(negedge clk);
         if (done != '0) seen++;
      end
      if (seen < n) check("done_timeout", seen, n);
   endtask

   // Monitor: accumulates the current burst and compares it on done.
   int              mon_pulses, mon_cycles;
   logic [NREQ-1:0] mon_gor;
   logic            mon_prev;
   always @(negedge clk) begin
      if (!rst_n) begin
         mon_pulses = 0;
         mon_cycles = 0;
         mon_gor    = '0;
         mon_prev   = 1'b0;
      end else begin
         if (gnt != '0) begin
            mon_cycles++;
            mon_gor = mon_gor | gnt;
         end
         if (led[0] && !mon_prev) mon_pulses++;
         mon_prev = led[0];
         if (done != '0) begin
            if (sb.size() == 0) begin
               check("sb_unexpected_done", done, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("sb_done",   done,       e.gnt);
               check("sb_owner",  mon_gor,    e.gnt);
               check("sb_pulses", mon_pulses, e.pulses);
               check("sb_cycles", mon_cycles, e.cycles);
               check("sb_gnt_off", gnt,       0);
               check("sb_busy",   {busy, led[1]}, 2'b11);
            end
            mon_pulses = 0;
            mon_cycles = 0;
            mon_gor    = '0;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [NREQ-1:0] quiet;
      rst_n     = 1'b0;
      req       = '0;
      burst_len = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_gnt",  gnt,  0);
      check("rst_done", done, 0);
      check("rst_busy", busy, 0);
      check("rst_led",  led,  0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // 1: single burst of 2 on requester 0, cycle-exact
      #1;
      req = 2'b01; burst_len = {4'd0, 4'd2};
      push_exp(2'b01, 2, 16);
      for (int k = 1; k <= 18; k++) begin
         @(posedge clk);
         @(negedge clk);
         check("t1_gnt",  gnt,  (k <= 16) ? 2'b01 : 2'b00);
         check("t1_done", done, (k == 17) ? 2'b01 : 2'b00);
         check("t1_led",  led,  {(k <= 17), (k <= 16 && ((k - 1) / 4) % 2 == 0)});
         check("t1_busy", busy, (k <= 17));
         if (k == 1) req = '0;
      end

      // 2: zero-length burst on requester 1
      @(posedge clk); #1;
      req = 2'b10; burst_len = {4'd0, 4'd5};
      push_exp(2'b10, 0, 1);
      @(negedge clk);
      check("t2_gnt",  gnt,  2'b10);
      check("t2_done0", done, 2'b00);
      @(posedge clk); #1;
      req = '0;
      @(negedge clk);
      check("t2_done", done, 2'b10);
      check("t2_gnt_off", gnt, 2'b00);
      check("t2_led0", led[0], 1'b0);
      @(negedge clk);
      check("t2_idle", {busy, done}, 3'b000);

      // 3: contention, both lengths 1
      @(posedge clk); #1;
      req = 2'b11; burst_len = {4'd1, 4'd1};
      for (int b = 0; b < 4; b++) begin
`ifdef LED_ARB_ROUND_ROBIN_EN
         push_exp((b % 2 == 0) ? 2'b01 : 2'b10, 1, 8);
`else
         push_exp(2'b01, 1, 8);
`endif
      end
      wait_dones(4, 60);
      req = '0;

      // 4: req and lengths change mid-burst
      repeat (2) @(posedge clk); #1;
      req = 2'b01; burst_len = {4'd0, 4'd2};
      push_exp(2'b01, 2, 16);
      repeat (2) @(posedge clk); #1;
      req = '0; burst_len = {4'd7, 4'd7};
      wait_dones(1, 40);
      quiet = '0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         quiet = quiet | gnt | done;
      end
      check("t4_quiet", quiet, 0);

      // 5: async reset three cycles into OFF
      @(posedge clk); #1;
      req = 2'b01; burst_len = {4'd0, 4'd3};
      repeat (7) @(posedge clk);
      #1;
      check("t5_pre_gnt", gnt, 2'b01);
      check("t5_pre_led", led, 2'b10);
      #1;
      rst_n = 1'b0;
      #1;
      check("t5_rst_gnt",  gnt,  0);
      check("t5_rst_done", done, 0);
      check("t5_rst_busy", busy, 0);
      check("t5_rst_led",  led,  0);
      req = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      req = 2'b11; burst_len = {4'd1, 4'd1};
      rst_n = 1'b1;
      push_exp(2'b01, 1, 8);
      @(posedge clk); #1;
      req = '0;
      @(negedge clk);
      check("t5_post_gnt", gnt, 2'b01);
      wait_dones(1, 30);

      // 6: maximum length
      repeat (2) @(posedge clk); #1;
      req = 2'b01; burst_len = {4'd0, 4'd15};
      push_exp(2'b01, 15, 120);
      @(posedge clk); #1;
      req = '0;
      wait_dones(1, 200);

      repeat (4) @(negedge clk);
      check("sb_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
